// File: rtl/c499_ecc_encoder.sv
// Streaming 32b -> 41b SEC encoder for the c499 corrector: two-stage pipeline,
// valid/ready on both sides, one-shot single-bit error injection, delivery counter.
module c499_ecc_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_r,
  input  logic             inj_arm,
  input  logic [5:0]       inj_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [40:0]      out_code,
  output logic             inj_armed,
  output logic [CNT_W-1:0] word_cnt
);

  logic             w_s1_adv, w_s2_adv, w_in_xfer, w_arm_ok, w_use_inj;
  logic [5:0]       w_idx;
  logic [40:0]      w_mask;
  logic [15:0]      w_part;
  logic [3:0]       w_par;
  logic [7:0]       w_chk;

  logic             r_s1_valid, r_s1_r, r_s2_valid, r_armed;
  logic [31:0]      r_s1_data;
  logic [40:0]      r_s1_mask, r_code;
  logic [15:0]      r_s1_part;
  logic [5:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign w_in_xfer = in_valid && w_s1_adv;

  // A same-cycle arm wins over a stale pending index.
  assign w_arm_ok  = inj_arm && (inj_idx <= 6'd40);
  assign w_use_inj = w_arm_ok || r_armed;
  assign w_idx     = w_arm_ok ? inj_idx : r_idx;
  assign w_mask    = w_use_inj ? (41'd1 << w_idx) : 41'd0;

  // Per byte: {byte parity, parity over bit-index bits 2,1,0 within the byte}.
  // Bits 3 and 4 of the data index select the byte, so stage 2 folds them in.
  always_comb begin
    w_part = '0;
    for (int b = 0; b < 4; b++) begin
      w_part[4*b+0] = ^(in_data[8*b +: 8] & 8'hAA);
      w_part[4*b+1] = ^(in_data[8*b +: 8] & 8'hCC);
      w_part[4*b+2] = ^(in_data[8*b +: 8] & 8'hF0);
      w_part[4*b+3] = ^in_data[8*b +: 8];
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) w_par[b] = r_s1_part[4*b+3];
    for (int k = 0; k < 3; k++)
      w_chk[k] = r_s1_part[k] ^ r_s1_part[4+k] ^ r_s1_part[8+k] ^ r_s1_part[12+k];
    w_chk[3] = w_par[1] ^ w_par[3];
    w_chk[4] = w_par[2] ^ w_par[3];
    w_chk[5] = ^w_par;
    w_chk[6] = w_par[0] ^ w_par[1];
    w_chk[7] = w_par[2] ^ w_par[3];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_r     <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mask  <= '0;
      r_s1_part  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_r    <= in_r;
        r_s1_data <= in_data;
        r_s1_mask <= w_mask;
        r_s1_part <= w_part;
      end
    end
  end

  // Mask applied after check computation: the flip looks like a channel error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_code     <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_code <= {r_s1_r, w_chk, r_s1_data} ^ r_s1_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
      r_idx   <= '0;
    end else if (w_in_xfer) begin
      r_armed <= 1'b0;
    end else if (w_arm_ok) begin
      r_armed <= 1'b1;
      r_idx   <= inj_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_cnt <= '0;
    else if (r_s2_valid && out_ready) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign out_valid = r_s2_valid;
  assign out_code  = r_code;
  assign inj_armed = r_armed;
  assign word_cnt  = r_cnt;

endmodule

// File: tb/tb_c499_ecc_encoder.sv
// Bench for c499_ecc_encoder: directed encodes, backpressure, injection, reset and
// counter wrap, plus a randomized stream scored against a bit-loop reference.
module tb_c499_ecc_encoder;
  localparam int CNT_W = 4;

  logic             clk = 1'b0, rst = 1'b1;
  logic             in_valid = 1'b0, in_r = 1'b0, inj_arm = 1'b0, out_ready = 1'b1;
  logic [31:0]      in_data = '0;
  logic [5:0]       inj_idx = '0;
  logic             in_ready, out_valid, inj_armed;
  logic [40:0]      out_code;
  logic [CNT_W-1:0] word_cnt;

  int n_chk = 0, n_fail = 0;

  logic [40:0]      exp_q[$];
  logic             m_armed = 1'b0, stall_prev = 1'b0, saw_block = 1'b0;
  logic [5:0]       m_idx = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [40:0]      prev_code = '0, last_code = '0, m_word = '0, m_got = '0;
  logic             m_armok;

  c499_ecc_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_r(in_r), .inj_arm(inj_arm), .inj_idx(inj_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .inj_armed(inj_armed), .word_cnt(word_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: walk the data bits and apply the column rules directly.
  function automatic logic [40:0] ref_enc(input logic [31:0] d, input logic r);
    logic [7:0] c = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) begin
        for (int j = 0; j < 5; j++) if (((i >> j) & 1) == 1) c[j] = ~c[j];
        c[5] = ~c[5];
        if (i < 16) c[6] = ~c[6];
        else        c[7] = ~c[7];
      end
    end
    return {r, c, d};
  endfunction

  // Monitor/model: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inj_armed", inj_armed, m_armed);
      chk("word_cnt", word_cnt, m_cnt);
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_code", out_code, prev_code);
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      m_armok = inj_arm && (inj_idx <= 6'd40);
      if (in_valid && in_ready) begin
        m_word = ref_enc(in_data, in_r);
        if (m_armok)      m_word[inj_idx] = ~m_word[inj_idx];
        else if (m_armed) m_word[m_idx]   = ~m_word[m_idx];
        m_armed = 1'b0;
        exp_q.push_back(m_word);
      end else if (m_armok) begin
        m_armed = 1'b1;
        m_idx   = inj_idx;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", out_code, 41'h0_dead_dead);
        else begin
          m_got = exp_q.pop_front();
          chk("out_code", out_code, m_got);
        end
        last_code = out_code;
        m_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      prev_code  = out_code;
    end
  end

  task automatic send(input logic [31:0] d, input logic r);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_r = r;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; inj_arm = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic arm(input logic [5:0] idx);
    inj_arm = 1'b1; inj_idx = idx;
    @(posedge clk); #1;
    inj_arm = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; inj_arm = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_inj_armed", inj_armed, 1'b0);
    chk("rst_word_cnt", word_cnt, '0);
    chk("rst_out_code", out_code, 41'h0);
    exp_q.delete(); m_armed = 1'b0; m_cnt = '0; stall_prev = 1'b0; saw_block = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_inj_armed", inj_armed, 1'b0);
    chk("init_word_cnt", word_cnt, '0);
    chk("init_out_code", out_code, 41'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Encode 0x1 with explicit latency check.
    in_valid = 1'b1; in_data = 32'h1; in_r = 1'b0;
    @(negedge clk);
    chk("lat_accept", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_n2_valid", out_valid, 1'b1);
    chk("enc_0x1", out_code, 41'h060_0000_0001);
    @(posedge clk); #1;
    drain();

    send(32'h3, 1'b0);          drain(); chk("enc_0x3", last_code, 41'h001_0000_0003);
    send(32'h8000_0000, 1'b1);  drain(); chk("enc_msb", last_code, 41'h1BF_8000_0000);
    send(32'hFFFF_FFFF, 1'b0);  drain(); chk("enc_ones", last_code, 41'h000_FFFF_FFFF);

    // Backpressure: out_ready low for 4 cycles mid-stream.
    do_reset();
    fork
      for (int w = 0; w < 5; w++) send(32'h1111_0000 + w, w[0]);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_dropped", saw_block, 1'b1);
    chk("bp_word_cnt", word_cnt, 4'd5);

    // Injection.
    arm(6'd3);
    chk("inj_armed_set", inj_armed, 1'b1);
    send(32'h0, 1'b0);
    chk("inj_armed_clr", inj_armed, 1'b0);
    drain(); chk("inj_bit3", last_code, 41'h000_0000_0008);
    arm(6'd36); send(32'h1, 1'b0); drain();
    chk("inj_bit36", last_code, 41'h070_0000_0001);
    arm(6'd45);
    chk("inj_45_ignored", inj_armed, 1'b0);
    arm(6'd5); arm(6'd45);
    chk("inj_45_keeps", inj_armed, 1'b1);
    send(32'h0, 1'b0); drain(); chk("inj_kept_5", last_code, 41'h000_0000_0020);

    // Arm in the same cycle as the transfer; re-arm overwrites, one-shot.
    inj_arm = 1'b1; inj_idx = 6'd10;
    send(32'h0, 1'b0); drain(); chk("inj_simul", last_code, 41'h000_0000_0400);
    arm(6'd2); arm(6'd7);
    send(32'h0, 1'b0); send(32'h0, 1'b0); drain();
    chk("inj_rearm_once", last_code, 41'h000_0000_0000);

    // Reset mid-stream with both stages full and an arm pending.
    out_ready = 1'b0;
    send(32'hAAAA_0001, 1'b0);
    send(32'hAAAA_0002, 1'b1);
    arm(6'd4);
    chk("pre_rst_full", out_valid, 1'b1);
    do_reset();
    out_ready = 1'b1;
    send(32'h1234_5678, 1'b1); drain();
    chk("post_rst_clean", last_code, ref_enc(32'h1234_5678, 1'b1));

    // Randomized stream with random arms and backpressure.
    fork
      for (int w = 0; w < 60; w++) begin
        inj_arm = ($urandom_range(0, 3) == 0);
        inj_idx = 6'($urandom_range(0, 47));
        send($urandom, 1'($urandom_range(0, 1)));
      end
      begin
        repeat (80) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Counter wrap at CNT_W=4.
    do_reset();
    for (int w = 0; w < 17; w++) send($urandom, 1'b0);
    drain();
    chk("wrap_word_cnt", word_cnt, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
